// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH synchronous divided clocks with rising-edge ticks.
// Each channel toggles its output every div_act clk cycles (50% duty). New
// ratios are staged in a shadow register and only take over at a half-period
// boundary, so no runt phase is ever produced. A sync pulse restarts every
// channel from a common phase so integer-related ratios share rising edges.
module multi_clock_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic                    load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       pend_o
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] div_act_reg;
      logic [CNT_W-1:0] div_sh_reg;
      logic [CNT_W-1:0] div_req;
      logic             pend_reg;
      logic             clk_reg;
      logic             tick_reg;
      logic             boundary;

      // A requested half-period of zero is meaningless; treat it as one.
      assign div_req  = (div_i[gi*CNT_W +: CNT_W] == '0) ? ONE
                                                         : div_i[gi*CNT_W +: CNT_W];
      // Last count of the current half-period.
      assign boundary = (cnt_reg == div_act_reg - ONE);

      // Half-period counter, output toggle, tick and shadow-ratio handover.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg     <= '0;
          div_act_reg <= DEF_DIV;
          div_sh_reg  <= DEF_DIV;
          pend_reg    <= 1'b0;
          clk_reg     <= 1'b0;
          tick_reg    <= 1'b0;
        end else if (sync) begin
          // Restart from the start of a low phase with the newest ratio.
          cnt_reg  <= '0;
          clk_reg  <= 1'b0;
          tick_reg <= 1'b0;
          pend_reg <= 1'b0;
          if (load) begin
            div_act_reg <= div_req;
            div_sh_reg  <= div_req;
          end else if (pend_reg) begin
            div_act_reg <= div_sh_reg;
          end
        end else begin
          tick_reg <= 1'b0;
          if (en) begin
            if (boundary) begin
              cnt_reg  <= '0;
              clk_reg  <= ~clk_reg;
              // Tick marks the 0->1 transition, landing with the high output.
              tick_reg <= ~clk_reg;
              if (pend_reg) begin
                div_act_reg <= div_sh_reg;
                pend_reg    <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + ONE;
            end
          end
          // A load always re-arms pend; if it coincides with a boundary the
          // handover above used the previous shadow value.
          if (load) begin
            div_sh_reg <= div_req;
            pend_reg   <= 1'b1;
          end
        end
      end

      assign clk_o[gi]  = clk_reg;
      assign tick_o[gi] = tick_reg;
      assign pend_o[gi] = pend_reg;
    end
  endgenerate

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised multi-channel clock divider that derives NUM_CH synchronous divided clocks, plus per-channel rising-edge tick pulses, from one fabric clock. It replaces fixed testbench clock generation (e.g. 16 MHz and 8 MHz from hand-written delays) with synthesizable, runtime-programmable ratios. Divide ratios can be reloaded glitch-free at period boundaries, and all channels can be re-phase-aligned on demand. It sits next to the clock source and feeds clock-enable consumers and the verification clock tree.

## Interface

- NUM_CH, 2, number of independent divider channels
- CNT_W, 8, width of each half-period count field
- DEFAULT_DIV, 4, half-period loaded into every channel at reset (must be ≥1 and < 2^CNT_W)

- clk  in  1  fabric clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global count enable; 0 freezes all channels
- div_i  in  NUM_CH*CNT_W  requested half-period per channel in clk cycles; channel k uses bits [k*CNT_W +: CNT_W]
- load  in  1  one-cycle pulse; capture div_i into shadow registers
- sync  in  1  one-cycle pulse; restart and phase-align all channels
- clk_o  out  NUM_CH  divided clock outputs, registered
- tick_o  out  NUM_CH  one-cycle pulse coincident with each clk_o 0→1
- pend_o  out  NUM_CH  shadow ratio captured but not yet active

## Operation

- Per-channel state: cnt (CNT_W), div_act (CNT_W), div_sh (CNT_W), pend, clk_o, tick_o.
- Reset: cnt=0, div_act=DEFAULT_DIV, div_sh=DEFAULT_DIV, pend=0, clk_o=0, tick_o=0, pend_o=0.
- Priority per cycle: rst > sync > load/count.
- Zero mapping: div_i field value 0 is treated as 1 wherever it is captured.
- Counting, with en=1 and no sync:
  - If cnt == div_act-1: cnt←0 and clk_o toggles.
  - At that same boundary, if pend=1: div_act←div_sh and pend←0. The new ratio governs the next half-period.
  - Otherwise cnt←cnt+1.
- tick_o: registered and asserted for exactly one cycle, in the same cycle clk_o first reads 1. It is driven when the boundary is hit while clk_o=0 and en=1. Otherwise tick_o=0.
- Output period is 2·div_act clk cycles at 50% duty. div_act=1 gives clk/2.
- en=0: cnt, clk_o and div_act hold; tick_o=0. load and sync are still honoured.
- load (no sync): all channels take div_sh←div_i field and pend←1. A load while pend=1 overwrites div_sh, and only the last value is applied. A load coinciding with a boundary sets pend for the following boundary; that boundary uses the old div_sh.
- sync: all channels take cnt←0, clk_o←0, tick_o←0.
  - If pend=1, div_act←div_sh and pend←0.
  - If load is asserted in the same cycle, div_act←div_i field directly and pend←0.
  - After sync, channels with ratios in integer relation have coincident rising edges.
- pend_o mirrors pend.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- Cycle numbering:
  - Cycle 0 is the first rising edge with rst=0, en=1, after reset or sync.
  - The first clk_o 0→1 and tick_o occur after edge div_act-1, i.e. they are visible in cycle div_act.
  - Subsequent rising edges follow every 2·div_act cycles.
- Ratio change latency: at most 2·div_act(old) cycles from load to the first half-period at the new ratio. No runt pulse is permitted; every high or low phase equals a full old or new half-period.
- sync takes effect on the next edge: clk_o=0 the cycle after sync.
- rst mid-period forces reset values on the next edge, regardless of en, load or sync.

## Test plan

- Reset with DEFAULT_DIV=4, en=1 → clk_o low for 4 cycles then high for 4 (period 8); tick_o pulses in cycles 4, 12, 20; pend_o=0.
- div_i={ch1=4, ch0=2} with load and sync together (models 16 MHz/8 MHz from 64 MHz) → ch0 period 4, ch1 period 8; rising edges coincide every 8 cycles; each tick_o is one cycle wide.
- load ch0=3 mid high-phase with old div 2 → pend_o[0]=1 until the next boundary; remaining phase is 2 cycles, then phases of 3; no phase shorter than 2; pend_o clears.
- Two loads before a boundary (5, then 6) → only 6 is applied; div_i=0 loaded → behaves as div 1 (clk/2).
- en dropped for 5 cycles mid-count → clk_o and cnt frozen, tick_o=0; on resume, the phase completes with its remaining count.
- rst asserted with pend=1 and clk_o=1 → next cycle: all outputs 0, div_act=DEFAULT_DIV.
